// File: rtl/proc_loader_pkg.sv
// Shared types and constants for the program loader.
package proc_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    DONE,
    ERR
  } state_t;

  localparam logic        REQ_WRITE         = 1'b1;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/proc_loader_packer.sv
// Byte-to-word assembler: four accepted bytes, little-endian, form one word.
module proc_loader_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_val
);

  logic [1:0]  idx;
  logic [23:0] bytes_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      bytes_q <= '0;
    end else if (clear) begin
      idx     <= '0;
    end else if (accept) begin
      idx     <= idx + 2'd1;
      bytes_q <= {data, bytes_q[23:8]};
    end
  end

  // The 4th byte is combined directly so the word is usable in its handshake cycle.
  assign word     = {data, bytes_q};
  assign word_val = accept && (idx == 2'd3);

endmodule

// File: rtl/proc_loader.sv
// Streams a length-prefixed program image into processor memory, holding the processor in reset.
module proc_loader
  import proc_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [7:0]  in_data,
  output logic        ext_dmemreq_val,
  output logic        ext_dmemreq_type,
  output logic [31:0] ext_dmemreq_addr,
  output logic [31:0] ext_dmemreq_wdata,
  output logic        proc_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum,
  output logic [31:0] word_cnt
);

  state_t      state, next_state;
  logic        clear, load_len, write_word;
  logic        accept, word_val;
  logic [31:0] word, len;

  assign accept = in_val && in_rdy;

  proc_loader_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .accept   (accept),
    .data     (in_data),
    .word     (word),
    .word_val (word_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    load_len   = 1'b0;
    write_word = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          next_state = HDR;
          clear      = 1'b1;
        end
      end
      HDR: begin
        if (word_val) begin
          load_len = 1'b1;
          if (word == '0)                   next_state = DONE;
          else if (word > 32'(MAX_WORDS))   next_state = ERR;
          else                              next_state = LOAD;
        end
      end
      LOAD: begin
        if (word_val) begin
          write_word = 1'b1;
          // Leave on the final word so DONE coincides with its write pulse.
          if (word_cnt + 32'd1 == len) next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_rdy   = (state == HDR) || (state == LOAD);
    busy     = in_rdy;
    done     = (state == DONE);
    err      = (state == ERR);
    proc_rst = (state != DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len               <= '0;
      word_cnt          <= '0;
      checksum          <= '0;
      ext_dmemreq_val   <= 1'b0;
      ext_dmemreq_addr  <= '0;
      ext_dmemreq_wdata <= '0;
    end else begin
      ext_dmemreq_val <= write_word;
      if (clear) begin
        word_cnt <= '0;
        checksum <= '0;
      end
      if (load_len) len <= word;
      if (write_word) begin
        ext_dmemreq_addr  <= BASE_ADDR + {word_cnt[29:0], 2'b00};
        ext_dmemreq_wdata <= word;
        word_cnt          <= word_cnt + 32'd1;
        checksum          <= checksum + word;
      end
    end
  end

  assign ext_dmemreq_type = ext_dmemreq_val & REQ_WRITE;

endmodule

// File: tb/tb_proc_loader.sv
// Directed bench for proc_loader: default-base and 0x200-base instances share one byte stream.
module tb_proc_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_val;
  logic [7:0]  in_data;

  logic        in_rdy, wval, wtype, proc_rst, busy, done, err;
  logic [31:0] waddr, wdata, checksum, word_cnt;
  logic        b_in_rdy, b_wval, b_wtype, b_proc_rst, b_busy, b_done, b_err;
  logic [31:0] b_waddr, b_wdata, b_checksum, b_word_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cnt;
    logic [31:0] sum;
    logic        typ;
    logic        done;
    logic        prst;
  } wr_t;

  wr_t q[$];
  wr_t qb[$];
  int unsigned dbl = 0;
  logic prev_v = 1'b0, prev_bv = 1'b0;

  always #5 clk = ~clk;

  proc_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_val(in_val), .in_rdy(in_rdy),
    .in_data(in_data), .ext_dmemreq_val(wval), .ext_dmemreq_type(wtype),
    .ext_dmemreq_addr(waddr), .ext_dmemreq_wdata(wdata), .proc_rst(proc_rst),
    .busy(busy), .done(done), .err(err), .checksum(checksum), .word_cnt(word_cnt)
  );

  proc_loader #(.BASE_ADDR(32'h0000_0200)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_val(in_val), .in_rdy(b_in_rdy),
    .in_data(in_data), .ext_dmemreq_val(b_wval), .ext_dmemreq_type(b_wtype),
    .ext_dmemreq_addr(b_waddr), .ext_dmemreq_wdata(b_wdata), .proc_rst(b_proc_rst),
    .busy(b_busy), .done(b_done), .err(b_err), .checksum(b_checksum), .word_cnt(b_word_cnt)
  );

  always @(negedge clk) begin
    if (wval) begin
      q.push_back('{waddr, wdata, word_cnt, checksum, wtype, done, proc_rst});
      if (prev_v) dbl++;
    end
    if (b_wval) begin
      qb.push_back('{b_waddr, b_wdata, b_word_cnt, b_checksum, b_wtype, b_done, b_proc_rst});
      if (prev_bv) dbl++;
    end
    prev_v  = wval;
    prev_bv = b_wval;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int unsigned gap);
    in_val = 1'b0;
    tick(gap);
    in_val  = 1'b1;
    in_data = b;
    tick(1);
    in_val = 1'b0;
  endtask

  logic [7:0]  s36 [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                            8'h73, 8'h00, 8'h00, 8'h00};
  logic [7:0]  s39 [12] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                            8'hFF, 8'hFF, 8'hFF, 8'hFF};
  int unsigned g39 [12] = '{0, 2, 1, 0, 3, 0, 0, 1, 2, 0, 1, 0};

  initial begin
    rst = 1'b0; start = 1'b0; in_val = 1'b0; in_data = '0;
    tick(3);
    rst = 1'b1;

    // Idle after reset release: nothing moves for 20 cycles.
    tick(20);
    check("rst_proc_rst", 32'(proc_rst), 32'd1);
    check("rst_in_rdy",   32'(in_rdy),   32'd0);
    check("rst_status",   {29'd0, busy, done, err}, 32'd0);
    check("rst_cnt",      word_cnt, 32'd0);
    check("rst_sum",      checksum, 32'd0);
    check("rst_wr",       {waddr | wdata}, 32'd0);
    check("rst_type",     32'(wtype), 32'd0);
    check("rst_writes",   32'(q.size()), 32'd0);

    // Two-word program, back-to-back bytes.
    pulse_start();
    check("hdr_busy", 32'(busy), 32'd1);
    check("hdr_rdy",  32'(in_rdy), 32'd1);
    check("hdr_prst", 32'(proc_rst), 32'd1);
    foreach (s36[i]) send(s36[i], 0);
    tick(3);
    check("p2_nwr", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      check("p2_a0",    q[0].addr, 32'h0000_0000);
      check("p2_d0",    q[0].data, 32'h0010_0513);
      check("p2_t0",    32'(q[0].typ), 32'd1);
      check("p2_c0",    q[0].cnt, 32'd1);
      check("p2_prst0", 32'(q[0].prst), 32'd1);
      check("p2_done0", 32'(q[0].done), 32'd0);
      check("p2_a1",    q[1].addr, 32'h0000_0004);
      check("p2_d1",    q[1].data, 32'h0000_0073);
      check("p2_c1",    q[1].cnt, 32'd2);
      check("p2_sum1",  q[1].sum, 32'h0010_0586);
      check("p2_done1", 32'(q[1].done), 32'd1);
      check("p2_prst1", 32'(q[1].prst), 32'd0);
    end
    check("p2_dbl",  32'(dbl), 32'd0);
    check("p2_type_idle", 32'(wtype), 32'd0);

    // Zero-length header: straight to DONE.
    q.delete(); qb.delete();
    pulse_start();
    check("z_prst_hdr", 32'(proc_rst), 32'd1);
    for (int i = 0; i < 4; i++) send(8'h00, 0);
    tick(3);
    check("z_done",   32'(done), 32'd1);
    check("z_prst",   32'(proc_rst), 32'd0);
    check("z_cnt",    word_cnt, 32'd0);
    check("z_writes", 32'(q.size()), 32'd0);

    // Oversize header 0x00001001 -> ERR; stream ignored while not ready.
    pulse_start();
    send(8'h01, 0); send(8'h10, 0); send(8'h00, 0); send(8'h00, 0);
    tick(1);
    check("e_err",  32'(err), 32'd1);
    check("e_prst", 32'(proc_rst), 32'd1);
    check("e_rdy",  32'(in_rdy), 32'd0);
    check("e_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) send(8'h01, 0);
    check("e_hold_err", 32'(err), 32'd1);
    check("e_writes",   32'(q.size()), 32'd0);
    pulse_start();
    check("e_rec_busy", 32'(busy), 32'd1);
    check("e_rec_err",  32'(err), 32'd0);
    check("e_rec_rdy",  32'(in_rdy), 32'd1);

    // Three-word load with gaps; a start mid-header must be ignored.
    send(8'h03, 1);
    send(8'h00, 0);
    pulse_start();
    send(8'h00, 1);
    send(8'h00, 0);
    foreach (s39[i]) send(s39[i], g39[i]);
    tick(3);
    check("g_nwr_b", 32'(qb.size()), 32'd3);
    check("g_nwr",   32'(q.size()), 32'd3);
    if (qb.size() == 3) begin
      check("g_a0", qb[0].addr, 32'h0000_0200);
      check("g_d0", qb[0].data, 32'h1122_3344);
      check("g_a1", qb[1].addr, 32'h0000_0204);
      check("g_d1", qb[1].data, 32'hA5A5_A5A5);
      check("g_a2", qb[2].addr, 32'h0000_0208);
      check("g_d2", qb[2].data, 32'hFFFF_FFFF);
      check("g_sum", qb[2].sum, 32'hB6C7_D8E8);
      check("g_done", 32'(qb[2].done), 32'd1);
    end
    if (q.size() == 3) check("g_a2_def", q[2].addr, 32'h0000_0008);
    check("g_dbl", 32'(dbl), 32'd0);

    // Reset mid-word: abort with word 0 written, word 1 never written.
    q.delete(); qb.delete();
    pulse_start();
    send(8'h04, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    for (int i = 1; i <= 6; i++) send(8'(i), 0);
    rst = 1'b0;
    in_val = 1'b1;
    in_data = 8'h07;
    #1;
    check("a_prst", 32'(proc_rst), 32'd1);
    check("a_rdy",  32'(in_rdy), 32'd0);
    check("a_val",  32'(wval), 32'd0);
    check("a_stat", {29'd0, busy, done, err}, 32'd0);
    check("a_cnt",  word_cnt, 32'd0);
    check("a_sum",  checksum, 32'd0);
    check("a_wr",   {waddr | wdata}, 32'd0);
    tick(3);
    in_val = 1'b0;
    rst = 1'b1;
    tick(10);
    check("a_nwr", 32'(q.size()), 32'd1);
    if (q.size() == 1) check("a_d0", q[0].data, 32'h0403_0201);
    check("a_idle_rdy", 32'(in_rdy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_loader.md
PROC_LOADER -- requirements
Module: proc_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 4096, largest legal program length in words.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port in_val  input  1  byte-stream valid.
REQ-007 SHALL have port in_rdy  output  1  byte-stream ready.
REQ-008 SHALL have port in_data  input  8  stream byte, little-endian within each word.
REQ-009 SHALL have port ext_dmemreq_val  output  1  write request to the processor's external memory port.
REQ-010 SHALL have port ext_dmemreq_type  output  1  request type; always 1 (write) while ext_dmemreq_val is high, 0 otherwise.
REQ-011 SHALL have port ext_dmemreq_addr  output  32  write byte address.
REQ-012 SHALL have port ext_dmemreq_wdata  output  32  write data.
REQ-013 SHALL have port proc_rst  output  1  active-high reset driven to the processor.
REQ-014 SHALL have ports busy, done, err  output  1 each  status flags.
REQ-015 SHALL have port checksum  output  32  sum of written words.
REQ-016 SHALL have port word_cnt  output  32  words written in the current load.

Function
REQ-017 SHALL implement states IDLE, HDR, LOAD, DONE, ERR.
REQ-018 IDLE: start -> HDR; clears word_cnt, checksum, byte index and err.
REQ-019 HDR: accepts 4 bytes forming the 32-bit length N (first byte = bits 7:0).
REQ-020 After the 4th header byte: N==0 -> DONE; N>MAX_WORDS -> ERR; otherwise -> LOAD.
REQ-021 in_rdy SHALL equal 1 exactly in HDR and LOAD; a byte transfers when in_val&&in_rdy.
REQ-022 LOAD: every 4 accepted bytes form a word; ext_dmemreq_val SHALL pulse for exactly one cycle, in the cycle after the 4th byte's handshake.
REQ-023 The k-th word (k from 0) SHALL be written to BASE_ADDR+4*k; address arithmetic wraps modulo 2^32.
REQ-024 Stream SHALL be accepted back-to-back, one byte per cycle, with no bubble around write pulses.
REQ-025 word_cnt and checksum (modulo 2^32 add of wdata) SHALL update in the same cycle as the write pulse.
REQ-026 On the write of word N-1 the FSM SHALL enter DONE in that same cycle.
REQ-027 proc_rst SHALL be 1 in IDLE, HDR, LOAD, ERR and 0 only in DONE, so processor dmem traffic never coincides with loader writes.
REQ-028 busy=1 in HDR/LOAD; done=1 in DONE; err=1 in ERR.
REQ-029 start in HDR or LOAD SHALL be ignored; start in DONE or ERR SHALL behave as from IDLE (proc_rst reasserted next cycle).
REQ-030 in_val while in_rdy=0 SHALL be ignored with no state change.

Reset
REQ-031 While rst=0: state IDLE, proc_rst=1, in_rdy=0, ext_dmemreq_val=0, type/addr/wdata=0, busy=done=err=0, checksum=word_cnt=0, byte index 0.
REQ-032 Reset asserted mid-load SHALL abort immediately with no further write pulse; partial words discarded.

Structure
REQ-033 State enum, REQ_WRITE constant and default BASE_ADDR SHALL live in shared package proc_loader_pkg.
REQ-034 A sub-module proc_loader_packer (byte-to-word assembler with 2-bit index and word-valid output) is natural and SHALL be used.

Verification
REQ-035 Reset release, no stimulus -> proc_rst=1, in_rdy=0, all status 0, no write pulse for 20 cycles.
REQ-036 start; bytes 02 00 00 00, 13 05 10 00, 73 00 00 00 back-to-back -> writes 0x00100513@0x0 and 0x00000073@0x4, word_cnt=2, checksum=0x00100586, done=1, proc_rst=0 same cycle as 2nd write.
REQ-037 Header 00 00 00 00 -> DONE with no write pulse, word_cnt=0.
REQ-038 Header length 0x00001001 (MAX_WORDS=4096) -> err=1, proc_rst stays 1, in_rdy=0; subsequent start recovers to HDR.
REQ-039 Random in_val gaps during a 3-word load with BASE_ADDR=0x200 -> writes at 0x200, 0x204, 0x208 only, each val one cycle.
REQ-040 rst asserted after 6 data bytes of a 4-word load -> outputs at reset values within the cycle; no write of word 1.
